// File: rtl/rr_arbiter_hold_pkg.sv
// Shared definitions for the round-robin hold arbiter: FSM state codes and
// an index-to-one-hot helper usable for any requester count up to 16.
package arb_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    function automatic logic [15:0] idx2onehot(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_hold_if.sv
// Requester-side bus of the arbiter: request levels in, registered grant,
// owner index, busy and preemption pulse out.
interface arb_if #(
    parameter int N_REQ = 4
);
    import arb_pkg::*;

    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] request;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic             preempt;

    modport master (
        input  request,
        output grant,
        output grant_id,
        output busy,
        output preempt
    );

    modport slave (
        output request,
        input  grant,
        input  grant_id,
        input  busy,
        input  preempt
    );

endinterface

// File: rtl/rr_arbiter_hold_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then map that offset back to an absolute index.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         request,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic                     any
);

    localparam int W = $clog2(N_REQ);
    localparam logic [W:0] NL = N_REQ[W:0];

    logic [N_REQ-1:0] w_rot;
    logic [W-1:0]     w_off;
    logic             w_found;

    // Modular add that stays correct for non-power-of-two requester counts.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= NL) s = s - NL;
        return s[W-1:0];
    endfunction

    always_comb begin
        w_rot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_rot[i] = request[wrap_add(i[W-1:0], ptr)];
        end
    end

    always_comb begin
        w_off   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_off   = i[W-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign sel = wrap_add(w_off, ptr);
    assign any = |request;

endmodule

// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with owner hold until release, bounded contended hold
// time with preemption, and one idle turnaround cycle between owners.
module rr_arbiter_hold #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic reset,
    arb_if.master bus
);
    import arb_pkg::*;

    localparam int IDW = $clog2(N_REQ);
    localparam int HW  = $clog2(MAX_HOLD);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N_REQ - 1);

    logic [0:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [HW-1:0]    r_hold_cnt;
    logic [N_REQ-1:0] r_grant;
    logic [IDW-1:0]   r_grant_id;
    logic             r_busy;
    logic             r_preempt;

    logic [0:0]       w_state_n;
    logic [IDW-1:0]   w_ptr_n;
    logic [HW-1:0]    w_hold_n;
    logic [N_REQ-1:0] w_grant_n;
    logic [IDW-1:0]   w_grant_id_n;
    logic             w_preempt_n;

    logic [IDW-1:0]   w_sel;
    logic             w_any;
    logic [N_REQ-1:0] w_sel_onehot;
    logic [IDW-1:0]   w_after_owner;
    logic             w_others_wait;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .request (bus.request),
        .ptr     (r_ptr),
        .sel     (w_sel),
        .any     (w_any)
    );

    assign w_sel_onehot  = N_REQ'(idx2onehot(4'(w_sel)));
    assign w_after_owner = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
    assign w_others_wait = |(bus.request & ~r_grant);

    always_comb begin
        w_state_n    = r_state;
        w_ptr_n      = r_ptr;
        w_hold_n     = r_hold_cnt;
        w_grant_n    = r_grant;
        w_grant_id_n = r_grant_id;
        w_preempt_n  = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant_n    = '0;
                w_grant_id_n = '0;
                if (w_any) begin
                    w_state_n    = GRANT;
                    w_grant_n    = w_sel_onehot;
                    w_grant_id_n = w_sel;
                    w_hold_n     = '0;
                end
            end
            GRANT: begin
                // Release is checked first so it wins over a coincident timeout.
                if (!bus.request[r_grant_id]) begin
                    w_state_n    = IDLE;
                    w_grant_n    = '0;
                    w_grant_id_n = '0;
                    w_ptr_n      = w_after_owner;
                end else if (r_hold_cnt == HOLD_LAST && w_others_wait) begin
                    w_state_n    = IDLE;
                    w_grant_n    = '0;
                    w_grant_id_n = '0;
                    w_ptr_n      = w_after_owner;
                    w_preempt_n  = 1'b1;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_n = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n    = IDLE;
                w_grant_n    = '0;
                w_grant_id_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_ptr      <= w_ptr_n;
            r_hold_cnt <= w_hold_n;
            r_grant    <= w_grant_n;
            r_grant_id <= w_grant_id_n;
            r_busy     <= |w_grant_n;
            r_preempt  <= w_preempt_n;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = r_busy;
    assign bus.preempt  = r_preempt;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Scenario bench for rr_arbiter_hold: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter_hold;

    localparam int N     = 4;
    localparam int MH    = 8;
    localparam int IDW   = $clog2(N);
    localparam int BOUND = (N - 1) * (MH + 1) + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arb_if #(.N_REQ(N)) bus ();

    rr_arbiter_hold #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run  = 0;
    int fail_count = 0;

    // Behavioural model state: owner index or -1 when nobody holds the resource.
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_pre;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.request = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_pre   = 0;
    endtask

    task automatic model_step(input logic [N-1:0] req);
        int unsigned rv;
        rv    = 32'(req);
        m_pre = 0;
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (m_owner < 0 && ((rv >> c) & 1) == 1) begin
                    m_owner = c;
                    m_hold  = 0;
                end
            end
        end else if (((rv >> m_owner) & 1) == 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_hold == MH - 1 && (rv & ~(32'd1 << m_owner)) != 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_pre   = 1;
        end else if (m_hold < MH - 1) begin
            m_hold = m_hold + 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.request = 4'b1111;
        tick();
        tick();
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0 || bus.preempt !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_hold: grant=%b busy=%b id=%0d preempt=%b, required 0000/0/0/0",
                     bus.grant, bus.busy, bus.grant_id, bus.preempt);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (bus.grant !== 4'b0001 || bus.busy !== 1'b1 || bus.grant_id !== 2'd0) begin
            fail_count++;
            $display("FAIL reset_first_grant: grant=%b busy=%b id=%0d, required 0001/1/0",
                     bus.grant, bus.busy, bus.grant_id);
        end
        bus.request = '0;
        tick();
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_release: grant=%b busy=%b, required 0000/0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.request = 4'b1010;
        for (int c = 0; c < MH; c++) begin
            tick();
            tests_run++;
            if (bus.grant !== 4'b0010 || bus.preempt !== 1'b0 || bus.grant_id !== 2'd1) begin
                fail_count++;
                $display("FAIL rr_own1 cycle %0d: grant=%b preempt=%b id=%0d, required 0010/0/1",
                         c, bus.grant, bus.preempt, bus.grant_id);
            end
        end
        tick();
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.preempt !== 1'b1) begin
            fail_count++;
            $display("FAIL rr_preempt1: grant=%b preempt=%b, required 0000/1", bus.grant, bus.preempt);
        end
        for (int c = 0; c < MH; c++) begin
            tick();
            tests_run++;
            if (bus.grant !== 4'b1000 || bus.preempt !== 1'b0 || bus.grant_id !== 2'd3) begin
                fail_count++;
                $display("FAIL rr_own3 cycle %0d: grant=%b preempt=%b id=%0d, required 1000/0/3",
                         c, bus.grant, bus.preempt, bus.grant_id);
            end
        end
        tick();
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.preempt !== 1'b1) begin
            fail_count++;
            $display("FAIL rr_preempt3: grant=%b preempt=%b, required 0000/1", bus.grant, bus.preempt);
        end
        tick();
        tests_run++;
        if (bus.grant !== 4'b0010 || bus.preempt !== 1'b0) begin
            fail_count++;
            $display("FAIL rr_back_to_1: grant=%b preempt=%b, required 0010/0", bus.grant, bus.preempt);
        end
        bus.request = '0;
        tick();
        tick();
    endtask

    task automatic test_release();
        do_reset();
        bus.request = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (bus.grant !== 4'b0100 || bus.grant_id !== 2'd2) begin
                fail_count++;
                $display("FAIL release_hold cycle %0d: grant=%b id=%0d, required 0100/2", c, bus.grant, bus.grant_id);
            end
        end
        bus.request = '0;
        tick();
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.preempt !== 1'b0 || bus.busy !== 1'b0) begin
            fail_count++;
            $display("FAIL release_drop: grant=%b preempt=%b busy=%b, required 0000/0/0",
                     bus.grant, bus.preempt, bus.busy);
        end
        bus.request = 4'b1111;
        tick();
        tests_run++;
        if (bus.grant !== 4'b1000) begin
            fail_count++;
            $display("FAIL release_ptr: grant=%b, required 1000", bus.grant);
        end
        bus.request = '0;
        tick();
        tick();
    endtask

    task automatic test_uncontended();
        do_reset();
        bus.request = 4'b0001;
        for (int c = 0; c < 50; c++) begin
            tick();
            tests_run++;
            if (bus.grant !== 4'b0001 || bus.preempt !== 1'b0) begin
                fail_count++;
                $display("FAIL uncontended cycle %0d: grant=%b preempt=%b, required 0001/0", c, bus.grant, bus.preempt);
            end
        end
        // A saturated counter must time out on the very first contended cycle.
        bus.request = 4'b0011;
        tick();
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.preempt !== 1'b1) begin
            fail_count++;
            $display("FAIL uncontended_saturate: grant=%b preempt=%b, required 0000/1", bus.grant, bus.preempt);
        end
        bus.request = '0;
        tick();
        tick();
    endtask

    task automatic test_release_at_timeout();
        do_reset();
        bus.request = 4'b0011;
        for (int c = 0; c < MH; c++) begin
            tick();
            tests_run++;
            if (bus.grant !== 4'b0001) begin
                fail_count++;
                $display("FAIL rat_hold cycle %0d: grant=%b, required 0001", c, bus.grant);
            end
        end
        bus.request = 4'b0100;
        tick();
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.preempt !== 1'b0) begin
            fail_count++;
            $display("FAIL rat_release: grant=%b preempt=%b, required 0000/0", bus.grant, bus.preempt);
        end
        bus.request = 4'b0101;
        tick();
        tests_run++;
        if (bus.grant !== 4'b0100) begin
            fail_count++;
            $display("FAIL rat_ptr: grant=%b, required 0100", bus.grant);
        end
        bus.request = '0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.request = 4'b0100;
        tick();
        bus.request = '0;
        tick();
        bus.request = 4'b1000;
        tick();
        tests_run++;
        if (bus.grant !== 4'b1000 || bus.grant_id !== 2'd3) begin
            fail_count++;
            $display("FAIL areset_setup: grant=%b id=%0d, required 1000/3", bus.grant, bus.grant_id);
        end
        tick();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0 || bus.preempt !== 1'b0) begin
            fail_count++;
            $display("FAIL areset_immediate: grant=%b busy=%b id=%0d preempt=%b, required 0000/0/0/0",
                     bus.grant, bus.busy, bus.grant_id, bus.preempt);
        end
        bus.request = 4'b1111;
        #1;
        reset = 1'b0;
        tick();
        tests_run++;
        if (bus.grant !== 4'b0001) begin
            fail_count++;
            $display("FAIL areset_ptr: grant=%b, required 0001", bus.grant);
        end
        bus.request = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0]   req;
        logic [N-1:0]   e_grant;
        logic [IDW-1:0] e_id;
        logic [N-1:0]   prev_grant;
        int             waitc [N];
        do_reset();
        model_reset();
        req        = '0;
        prev_grant = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (bit_of(req, i)) begin
                    if ($urandom_range(15) == 0) req = req & ~(N'(1) << i);
                end else if ($urandom_range(3) == 0) begin
                    req = req | (N'(1) << i);
                end
            end
            bus.request = req;
            model_step(req);
            tick();
            e_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
            e_id    = (m_owner < 0) ? '0 : IDW'(m_owner);
            tests_run++;
            if (bus.grant !== e_grant || bus.grant_id !== e_id || bus.busy !== (m_owner >= 0)
                || bus.preempt !== (m_pre == 1)) begin
                fail_count++;
                $display("FAIL random cycle %0d: grant=%b id=%0d busy=%b preempt=%b, required %b/%0d/%b/%b",
                         cyc, bus.grant, bus.grant_id, bus.busy, bus.preempt,
                         e_grant, e_id, (m_owner >= 0), (m_pre == 1));
            end
            if (prev_grant != '0 && bus.grant != '0) begin
                tests_run++;
                if (bus.grant !== prev_grant) begin
                    fail_count++;
                    $display("FAIL turnaround cycle %0d: grant=%b after %b, required an idle cycle between owners",
                             cyc, bus.grant, prev_grant);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bit_of(req, i) && bit_of(bus.grant, i)) begin
                    tests_run++;
                    if (waitc[i] > BOUND) begin
                        fail_count++;
                        $display("FAIL wait_bound req %0d: waited %0d cycles, required <= %0d", i, waitc[i], BOUND);
                    end
                    waitc[i] = 0;
                end else if (bit_of(req, i)) begin
                    waitc[i]++;
                end else begin
                    waitc[i] = 0;
                end
            end
            prev_grant = bus.grant;
        end
        bus.request = '0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.request = '0;
        test_reset();
        test_round_robin();
        test_release();
        test_uncontended();
        test_release_at_timeout();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
